// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_pkg
//  Description : Register map, CONFIG field layout and bus helpers shared by
//                the PWM peripheral and its channels.
//  Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    // Byte offsets of the register map (low two address bits are ignored)
    localparam logic [4:0] PWM_CONFIG       = 5'h00;
    localparam logic [4:0] PWM_TOP          = 5'h04;
    localparam logic [4:0] PWM_COUNTER      = 5'h08;
    localparam logic [4:0] PWM_COMPARE_BASE = 5'h10;

    // CONFIG field positions
    localparam int PWM_CFG_ENABLE_BIT = 0;
    localparam int PWM_CFG_SCALE_LSB  = 1;
    localparam int PWM_SCALE_W        = 3;

    // Prescaler must count up to 2^7-1 for the largest scale setting
    localparam int PWM_PRESC_W = 7;

    // Packed so that a zero-extending cast gives the CONFIG readback layout
    typedef struct packed {
        logic [PWM_SCALE_W-1:0] scale;
        logic                   enable;
    } pwm_cfg_t;

    // Byte-enable merge of a bus write into an existing 32-bit value
    function automatic logic [31:0] pwm_merge(
        input logic [31:0] old_val,
        input logic [31:0] wdata,
        input logic [3:0]  sel
    );
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
                res[8*b +: 8] = wdata[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_device_if.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_device_if
//  Description : Peripheral bus bundle between the bus fabric (master) and
//                the PWM device (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface pwm_device_if;

    logic        bus_cs;
    logic        bus_we;
    logic        bus_oe;
    logic [4:0]  bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_cs,
        output bus_we,
        output bus_oe,
        output bus_addr,
        output bus_sel,
        output bus_wdata,
        input  bus_rdata,
        input  bus_ack
    );

    modport slave (
        input  bus_cs,
        input  bus_we,
        input  bus_oe,
        input  bus_addr,
        input  bus_sel,
        input  bus_wdata,
        output bus_rdata,
        output bus_ack
    );

endinterface
`default_nettype wire

// File: rtl/pwm_channel.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_channel
//  Description : One compare channel: software-visible buffer register,
//                double-buffered active compare value and registered output.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wrap_i,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] counter_i,
    input  logic             we_i,
    input  logic [3:0]       sel_i,
    input  logic [31:0]      wdata_i,
    output logic [WIDTH-1:0] buffer_o,
    output logic             pwm_o
);

    logic [WIDTH-1:0] buffer_q, buffer_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic             out_q, out_d;

    // Next-state: buffer takes bus writes, active follows buffer on wrap or while stopped
    always_comb begin
        buffer_d = buffer_q;
        if (we_i) begin
            buffer_d = WIDTH'(pwm_merge(32'(buffer_q), wdata_i, sel_i));
        end

        active_d = active_q;
        if (!enable_i) begin
            // Stopped: software sees its compare value take effect at once
            active_d = buffer_d;
        end else if (wrap_i) begin
            // A write landing on the wrap edge is picked up one period later
            active_d = buffer_q;
        end

        out_d = enable_i && (counter_i >= active_q);
    end

    // State update with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buffer_q <= '0;
            active_q <= '0;
            out_q    <= 1'b0;
        end else begin
            buffer_q <= buffer_d;
            active_q <= active_d;
            out_q    <= out_d;
        end
    end

    assign buffer_o = buffer_q;
    assign pwm_o    = out_q;

endmodule
`default_nettype wire

// File: rtl/pwm_device.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_device
//  Description : Register-programmable PWM generator. Shared prescaler and
//                period counter feeding OUTPUTS compare channels, programmed
//                over a simple peripheral bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_device
    import pwm_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int OUTPUTS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    pwm_device_if.slave        bus,
    output logic [OUTPUTS-1:0] pwm_out
);

    // ---------------------------------------------------------------- decode
    logic             w_req;
    logic             w_wr;
    logic             w_rd;
    logic [4:0]       w_off;
    logic             w_wr_cfg;
    logic             w_wr_top;
    logic             w_wr_cnt;
    logic             w_unused_addr;

    assign w_req    = bus.bus_cs && (bus.bus_we || bus.bus_oe);
    assign w_wr     = bus.bus_cs && bus.bus_we;
    assign w_rd     = bus.bus_cs && bus.bus_oe;
    assign w_off    = {bus.bus_addr[4:2], 2'b00};
    assign w_wr_cfg = w_wr && (w_off == PWM_CONFIG);
    assign w_wr_top = w_wr && (w_off == PWM_TOP);
    assign w_wr_cnt = w_wr && (w_off == PWM_COUNTER);

    // Byte lanes within a word are not decoded
    assign w_unused_addr = ^bus.bus_addr[1:0];

    // ------------------------------------------------------------- registers
    pwm_cfg_t                cfg_q, cfg_d;
    logic [WIDTH-1:0]        top_q, top_d;
    logic [WIDTH-1:0]        cnt_q, cnt_d;
    logic [PWM_PRESC_W-1:0]  presc_q, presc_d;
    logic                    ack_q;
    logic [31:0]             rdata_q, rdata_d;

    logic [PWM_PRESC_W-1:0]  w_limit;
    logic                    w_tick;
    logic                    w_wrap;
    logic                    w_disable;

    logic [WIDTH-1:0]        chan_buf [OUTPUTS];
    logic [OUTPUTS-1:0]      w_chan_we;

    // Terminal prescaler count is 2^scale - 1
    assign w_limit   = ~({PWM_PRESC_W{1'b1}} << cfg_q.scale);
    // >= keeps the prescaler from running away if scale shrinks while enabled
    assign w_tick    = cfg_q.enable && (presc_q >= w_limit);
    // A COUNTER write wins over a same-cycle tick, so it also suppresses the wrap
    assign w_wrap    = w_tick && !w_wr_cnt && (cnt_q >= top_q);
    assign w_disable = cfg_q.enable && !cfg_d.enable;

    // Next-state for config, top, prescaler and period counter
    always_comb begin
        cfg_d = cfg_q;
        if (w_wr_cfg && bus.bus_sel[0]) begin
            cfg_d.enable = bus.bus_wdata[PWM_CFG_ENABLE_BIT];
            cfg_d.scale  = bus.bus_wdata[PWM_CFG_SCALE_LSB +: PWM_SCALE_W];
        end

        top_d = top_q;
        if (w_wr_top) begin
            top_d = WIDTH'(pwm_merge(32'(top_q), bus.bus_wdata, bus.bus_sel));
        end

        // Prescaler runs only across cycles where the enable stays set
        if (!cfg_q.enable || !cfg_d.enable || w_wr_cnt || w_tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PWM_PRESC_W'(1);
        end

        cnt_d = cnt_q;
        if (w_wr_cnt) begin
            cnt_d = WIDTH'(pwm_merge(32'(cnt_q), bus.bus_wdata, bus.bus_sel));
        end else if (w_disable) begin
            cnt_d = '0;
        end else if (w_tick) begin
            cnt_d = w_wrap ? '0 : cnt_q + WIDTH'(1);
        end
    end

    // Readback mux; data is only driven in the acknowledge cycle
    always_comb begin
        rdata_d = '0;
        if (w_rd) begin
            if (w_off == PWM_CONFIG) begin
                rdata_d = 32'(cfg_q);
            end else if (w_off == PWM_TOP) begin
                rdata_d = 32'(top_q);
            end else if (w_off == PWM_COUNTER) begin
                rdata_d = 32'(cnt_q);
            end else begin
                for (int i = 0; i < OUTPUTS; i++) begin
                    if ({27'd0, w_off} == 32'(PWM_COMPARE_BASE) + 32'(4 * i)) begin
                        rdata_d = 32'(chan_buf[i]);
                    end
                end
            end
        end
    end

    // Register update with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg_q   <= '0;
            top_q   <= '0;
            cnt_q   <= '0;
            presc_q <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            cfg_q   <= cfg_d;
            top_q   <= top_d;
            cnt_q   <= cnt_d;
            presc_q <= presc_d;
            ack_q   <= w_req;
            rdata_q <= rdata_d;
        end
    end

    assign bus.bus_ack   = ack_q;
    assign bus.bus_rdata = rdata_q;

    // ------------------------------------------------------------- channels
    // With a 5-bit address only COMPARE[0..3] fall inside the window; any
    // higher channel never matches and keeps its reset compare value.
    for (genvar g = 0; g < OUTPUTS; g++) begin : g_chan
        assign w_chan_we[g] = w_wr &&
            ({27'd0, w_off} == 32'(PWM_COMPARE_BASE) + 32'(4 * g));

        pwm_channel #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .wrap_i    (w_wrap),
            .enable_i  (cfg_q.enable),
            .counter_i (cnt_q),
            .we_i      (w_chan_we[g]),
            .sel_i     (bus.bus_sel),
            .wdata_i   (bus.bus_wdata),
            .buffer_o  (chan_buf[g]),
            .pwm_o     (pwm_out[g])
        );
    end

endmodule
`default_nettype wire
